conv_encoder: RTL and testbench

Rate-1/2, constraint-length-3 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder's branch-metric and ACS path.
- Consumes a framed serial bit stream over a valid/ready handshake.
- Emits one 2-bit code pair per input bit.
- Optionally appends K-1 = 2 zero tail bits per frame, so the trellis terminates in state 00 as the decoder's traceback expects.
- Sits between the source/test-pattern generator and the channel model feeding the decoder.

---
 rtl/conv_encoder.sv | 125 ++++++++++++
 tb/tb_conv_encoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// -----------------------------------------------------------------------------
// conv_encoder
//
// Rate-1/2, constraint-length-3 convolutional encoder. It takes a framed serial
// bit stream and produces one 2-bit code pair per input bit. With TERMINATE=1
// it appends two zero tail bits to each frame, so the trellis ends in state 00
// where the decoder's traceback expects it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_bit / in_last are valid
//   in_ready   encoder accepts a bit this cycle
//   in_bit     data bit
//   in_last    final data bit of the frame
//   out_valid  out_pair / out_last are valid
//   out_ready  downstream accepts a pair this cycle
//   out_pair   [1] = G0 parity, [0] = G1 parity
//   out_last   final pair of the frame (last tail pair when TERMINATE=1)
//   busy       frame in progress or a pair still waiting to be taken
// -----------------------------------------------------------------------------
module conv_encoder #(
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101,
  parameter bit         TERMINATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_pair,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_e;

  state_e     state_q;
  logic [1:0] shift_q;
  logic       tailCnt_q;
  logic       outValid_q;
  logic [1:0] outPair_q;
  logic       outLast_q;

  logic       adv;
  logic       encBit_d;
  logic [2:0] window_d;
  logic [1:0] encPair_d;

  // The output register can be reloaded whenever it is empty or being drained
  // this cycle; input is only taken when no tail bits are still owed.
  assign adv      = !outValid_q || out_ready;
  assign in_ready = adv && (state_q != TAIL);

  // Tail bits are encoded as zeros; the window holds the newest bit in bit 2
  // so it lines up with the generator tap ordering.
  assign encBit_d  = (state_q == TAIL) ? 1'b0 : in_bit;
  assign window_d  = {encBit_d, shift_q};
  assign encPair_d = {^(window_d & G0), ^(window_d & G1)};

  // Single FSM process: it owns the shift state, the tail counter and the
  // registered output pair. Nothing moves unless the output register can
  // advance, which is what keeps the pair and the shift state frozen during a
  // downstream stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= 2'b00;
      tailCnt_q  <= 1'b0;
      outValid_q <= 1'b0;
      outPair_q  <= 2'b00;
      outLast_q  <= 1'b0;
    end else if (adv) begin
      if (state_q == TAIL) begin
        outValid_q <= 1'b1;
        outPair_q  <= encPair_d;
        shift_q    <= {1'b0, shift_q[1]};
        if (tailCnt_q) begin
          outLast_q <= 1'b1;
          tailCnt_q <= 1'b0;
          state_q   <= IDLE;
        end else begin
          outLast_q <= 1'b0;
          tailCnt_q <= 1'b1;
        end
      end else if (in_valid) begin
        outValid_q <= 1'b1;
        outPair_q  <= encPair_d;
        if (in_last) begin
          if (TERMINATE) begin
            outLast_q <= 1'b0;
            shift_q   <= {in_bit, shift_q[1]};
            state_q   <= TAIL;
          end else begin
            // Without a tail the frame ends here, so the next frame must start
            // from the all-zero state.
            outLast_q <= 1'b1;
            shift_q   <= 2'b00;
            state_q   <= IDLE;
          end
        end else begin
          outLast_q <= 1'b0;
          shift_q   <= {in_bit, shift_q[1]};
          state_q   <= DATA;
        end
      end else begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_valid = outValid_q;
  assign out_pair  = outPair_q;
  assign out_last  = outLast_q;
  assign busy      = (state_q != IDLE) || outValid_q;

endmodule

// File: tb/tb_conv_encoder.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder
//
// Two encoders share the clock, reset and stimulus: index 0 is built with
// TERMINATE=0 and index 1 with TERMINATE=1. 'sel' steers in_valid to one of
// them. The reference model treats each frame as an array of bits and forms
// every code pair as a modulo-2 convolution of that array with the generator
// taps, with bits before the frame start taken as zero.
// -----------------------------------------------------------------------------
module tb_conv_encoder;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       inValid;
  logic       inBit;
  logic       inLast;
  logic       outReady;
  int         readyMode;

  logic       inValidD [2];
  logic       inReady  [2];
  logic       outValid [2];
  logic [1:0] outPair  [2];
  logic       outLast  [2];
  logic       busy     [2];

  int checks = 0;
  int errors = 0;

  // Model state: frame bits per encoder, expected entries {tail,last,pair[1:0]}
  logic       frameBits [2][0:299];
  int         framePos  [2];
  logic [3:0] expQ0 [$];
  logic [3:0] expQ1 [$];
  logic [2:0] rxLog [$];
  bit         stallPrev [2];
  logic [2:0] heldVal   [2];

  always #5 clk = ~clk;

  assign inValidD[0] = inValid && !sel;
  assign inValidD[1] = inValid && sel;

  conv_encoder #(.G0(G0), .G1(G1), .TERMINATE(1'b0)) dutNoTail (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValidD[0]), .in_ready(inReady[0]),
    .in_bit(inBit), .in_last(inLast),
    .out_valid(outValid[0]), .out_ready(outReady),
    .out_pair(outPair[0]), .out_last(outLast[0]), .busy(busy[0])
  );

  conv_encoder #(.G0(G0), .G1(G1), .TERMINATE(1'b1)) dutTail (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValidD[1]), .in_ready(inReady[1]),
    .in_bit(inBit), .in_last(inLast),
    .out_valid(outValid[1]), .out_ready(outReady),
    .out_pair(outPair[1]), .out_last(outLast[1]), .busy(busy[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Code pair n of a frame: parity of taps over bits n, n-1, n-2.
  function automatic logic [1:0] codePair(input int k, input int n);
    logic p1;
    logic p0;
    p1 = 1'b0;
    p0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (n - j >= 0) begin
        if (G0[2-j]) p1 = p1 ^ frameBits[k][n-j];
        if (G1[2-j]) p0 = p0 ^ frameBits[k][n-j];
      end
    end
    return {p1, p0};
  endfunction

  function automatic void qPush(input int k, input logic [3:0] v);
    if (k == 0) expQ0.push_back(v);
    else        expQ1.push_back(v);
  endfunction

  function automatic int qSize(input int k);
    return (k == 0) ? expQ0.size() : expQ1.size();
  endfunction

  function automatic logic [3:0] qHead(input int k);
    return (k == 0) ? expQ0[0] : expQ1[0];
  endfunction

  function automatic void qPop(input int k);
    if (k == 0) void'(expQ0.pop_front());
    else        void'(expQ1.pop_front());
  endfunction

  function automatic int qTails(input int k);
    int n;
    n = 0;
    if (k == 0) begin
      foreach (expQ0[i]) if (expQ0[i][3]) n++;
    end else begin
      foreach (expQ1[i]) if (expQ1[i][3]) n++;
    end
    return n;
  endfunction

  // Record an accepted bit and queue every pair it causes, including the tail.
  function automatic void modelAccept(input int k, input logic b, input logic l);
    int p;
    p = framePos[k];
    frameBits[k][p] = b;
    if (l && k == 0) begin
      qPush(k, {2'b01, codePair(k, p)});
      framePos[k] = 0;
    end else if (l) begin
      qPush(k, {2'b00, codePair(k, p)});
      frameBits[k][p+1] = 1'b0;
      qPush(k, {2'b10, codePair(k, p + 1)});
      frameBits[k][p+2] = 1'b0;
      qPush(k, {2'b11, codePair(k, p + 2)});
      framePos[k] = 0;
    end else begin
      qPush(k, {2'b00, codePair(k, p)});
      framePos[k] = p + 1;
    end
  endfunction

  // Compare process: on every falling edge both encoders are checked against
  // the model for valid, ready, busy, pair content and stall stability, and
  // any handshake about to happen on the coming rising edge is applied.
  always @(negedge clk) begin
    logic [3:0] head;
    logic       expValid;
    logic       expReady;
    int         tails;
    if (!rst_n) begin
      expQ0.delete();
      expQ1.delete();
      framePos[0]  = 0;
      framePos[1]  = 0;
      stallPrev[0] = 1'b0;
      stallPrev[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        expValid = qSize(k) > 0;
        head     = expValid ? qHead(k) : 4'h0;
        tails    = qTails(k) - ((expValid && head[3]) ? 1 : 0);
        expReady = (!expValid || outReady) && (tails == 0);
        checkOutput($sformatf("out_valid[%0d]", k), 32'(outValid[k]), 32'(expValid));
        checkOutput($sformatf("in_ready[%0d]", k), 32'(inReady[k]), 32'(expReady));
        checkOutput($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(expValid || framePos[k] > 0));
        if (stallPrev[k])
          checkOutput($sformatf("stall_hold[%0d]", k), 32'({outLast[k], outPair[k]}), 32'(heldVal[k]));
        if (expValid && outValid[k]) begin
          checkOutput($sformatf("out_pair[%0d]", k), 32'(outPair[k]), 32'(head[1:0]));
          checkOutput($sformatf("out_last[%0d]", k), 32'(outLast[k]), 32'(head[2]));
          if (outReady) begin
            qPop(k);
            if (k == int'(sel)) rxLog.push_back({outLast[k], outPair[k]});
          end
          stallPrev[k] = !outReady;
          heldVal[k]   = {outLast[k], outPair[k]};
        end else begin
          stallPrev[k] = 1'b0;
        end
        if (inValidD[k] && inReady[k]) modelAccept(k, inBit, inLast);
      end
    end
  end

  // out_ready pattern generator: 0 = always ready, 1 = 1,0,0 repeating,
  // 2 = random with roughly 70% duty.
  initial begin
    int cnt;
    cnt      = 0;
    outReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      case (readyMode)
        0:       outReady = 1'b1;
        1:       outReady = (cnt % 3 == 0);
        default: outReady = ($urandom_range(99) < 70);
      endcase
    end
  end

  // Offer one bit until it is accepted; returns just after the accepting edge.
  task automatic sendBit(input logic b, input logic l);
    logic accepted;
    accepted = 1'b0;
    inValid  = 1'b1;
    inBit    = b;
    inLast   = l;
    for (int t = 0; t < 500 && !accepted; t++) begin
      @(negedge clk);
      accepted = inReady[sel];
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Send a frame of n bits (bits[0] first) to encoder k, with optional idle gaps.
  task automatic applyStimulus(input int k, input logic [255:0] bits, input int n, input int gapPct);
    sel = (k != 0);
    rxLog.delete();
    for (int i = 0; i < n; i++) begin
      while (gapPct > 0 && $urandom_range(99) < gapPct) begin
        inValid = 1'b0;
        @(posedge clk);
        #1;
      end
      sendBit(bits[i], i == n - 1);
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = (expQ0.size() == 0) && (expQ1.size() == 0);
    end
    if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Compare the received pairs of the last frame with a literal list; entry i
  // sits at exp[3i+2:3i] as {last, pair}.
  task automatic checkLog(input string name, input logic [47:0] exp, input int n);
    checkOutput({name, "_count"}, 32'(rxLog.size()), 32'(n));
    for (int i = 0; i < n && i < rxLog.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), 32'(rxLog[i]), 32'(exp[3*i +: 3]));
  endtask

  initial begin
    logic [255:0] rb;
    int           cnt;
    int           bitErr;
    rst_n     = 1'b0;
    sel       = 1'b1;
    inValid   = 1'b0;
    inBit     = 1'b0;
    inLast    = 1'b0;
    readyMode = 0;

    #12;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_out_valid", 32'(outValid[k]), 32'd0);
      checkOutput("reset_out_pair", 32'(outPair[k]), 32'd0);
      checkOutput("reset_out_last", 32'(outLast[k]), 32'd0);
      checkOutput("reset_busy", 32'(busy[k]), 32'd0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready0", 32'(inReady[0]), 32'd1);
    checkOutput("reset_in_ready1", 32'(inReady[1]), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] frame 1,0,1,1 with tail, out_ready high");
    applyStimulus(1, 256'hD, 4, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inReady[1]) break;
      cnt++;
    end
    checkOutput("tail_ready_low_cycles", 32'(cnt), 32'd2);
    waitDrain();
    checkLog("frame1011", {3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6);

    $display("[TB] same frame with out_ready 1,0,0 pattern");
    readyMode = 1;
    applyStimulus(1, 256'hD, 4, 0);
    waitDrain();
    checkLog("stall1011", {3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6);
    @(negedge clk);
    checkOutput("busy_after_frame", 32'(busy[1]), 32'd0);
    readyMode = 0;
    @(posedge clk);
    #1;

    $display("[TB] single-bit frame with tail");
    applyStimulus(1, 256'h1, 1, 0);
    waitDrain();
    checkLog("single1", {27'd0, 3'b111, 3'b010, 3'b011}, 3);

    $display("[TB] back-to-back frames 1,0 then 1");
    sel = 1'b1;
    rxLog.delete();
    sendBit(1'b1, 1'b0);
    sendBit(1'b0, 1'b1);
    sendBit(1'b1, 1'b1);
    inValid = 1'b0;
    inLast  = 1'b0;
    waitDrain();
    checkOutput("b2b_count", 32'(rxLog.size()), 32'd7);
    if (rxLog.size() == 7) begin
      checkOutput("b2b_tail_last", 32'(rxLog[3]), 32'(3'b100));
      checkOutput("b2b_next_first", 32'(rxLog[4]), 32'(3'b011));
      checkOutput("b2b_final", 32'(rxLog[6]), 32'(3'b111));
    end

    $display("[TB] no-tail encoder: frame 1,1 then frame 1");
    applyStimulus(0, 256'h3, 2, 0);
    waitDrain();
    checkLog("notail11", {42'd0, 3'b101, 3'b011}, 2);
    applyStimulus(0, 256'h1, 1, 0);
    waitDrain();
    checkLog("notail1", {45'd0, 3'b111}, 1);

    $display("[TB] reset during second tail cycle");
    applyStimulus(1, 256'hD, 4, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(outValid[1]), 32'd0);
    checkOutput("midreset_out_pair", 32'(outPair[1]), 32'd0);
    checkOutput("midreset_out_last", 32'(outLast[1]), 32'd0);
    checkOutput("midreset_busy", 32'(busy[1]), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 256'hD, 4, 0);
    waitDrain();
    checkLog("after_reset", {3'b111, 3'b001, 3'b001, 3'b000, 3'b010, 3'b011}, 6);

    $display("[TB] 256 random bits, random valid/ready duty");
    for (int i = 0; i < 256; i++) rb[i] = 1'($urandom_range(1));
    readyMode = 2;
    applyStimulus(1, rb, 256, 30);
    waitDrain();
    readyMode = 0;
    checkOutput("random_count", 32'(rxLog.size()), 32'd258);
    // For these generators pair[1]^pair[0] of pair n recovers bit n-1.
    bitErr = 0;
    if (rxLog.size() == 258) begin
      for (int i = 0; i < 256; i++)
        if ((rxLog[i+1][1] ^ rxLog[i+1][0]) !== rb[i]) bitErr++;
    end else begin
      bitErr = -1;
    end
    checkOutput("decoded_bit_errors", 32'(bitErr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
